// File: rtl/fpgaudio_pkg.sv
// Shared FPGAudio definitions: control-unit state codes and song-word constants.
// Song words are packed {nota, duracao}, nota in the upper bits.
package fpgaudio_pkg;

   typedef enum logic [3:0] {
      INICIAL          = 4'd0,
      ZERA             = 4'd1,
      ESPERA           = 4'd2,
      MEDE             = 4'd3,
      GRAVA            = 4'd4,
      INCREMENTA       = 4'd5,
      GRAVA_FIM        = 4'd6,
      FIM              = 4'd7,
      GRAVA_PAUSA      = 4'd8,
      INCREMENTA_PAUSA = 4'd9
   } estado_t;

   // Replicated across the nota field: all ones marks end of song, all zeros a rest.
   localparam logic END_MARKER_NOTA_BIT = 1'b1;
   localparam logic PAUSA_NOTA_BIT      = 1'b0;

endpackage

// File: rtl/contador_duracao.sv
// Saturating metronome-tick counter; o_proxima is the value the counter takes at
// the next edge, so a tick arriving on the closing cycle is already included.
module contador_duracao #(
   parameter int DUR_W = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_zera,
   input  logic             i_conta,
   input  logic             i_tick,
   output logic [DUR_W-1:0] o_proxima
);

   logic [DUR_W-1:0] r_cont;

   always_comb begin
      o_proxima = r_cont;
      if (i_zera)
         o_proxima = '0;
      else if (i_conta && i_tick && (r_cont != '1))
         o_proxima = r_cont + 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset)
         r_cont <= '0;
      else
         r_cont <= o_proxima;
   end

endmodule

// File: rtl/modo2_gravador.sv
// Mode-2 recorder: writes {nota, duracao} words and an end marker into song RAM.
// Define GRAVA_PAUSAS_EN to also record rest words for silence between notes.
module modo2_gravador
   import fpgaudio_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int NOTA_W = 4,
   parameter int DUR_W  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    iniciar,
   input  logic                    press_enter,
   input  logic                    nota_feita,
   input  logic [NOTA_W-1:0]       nota,
   input  logic                    tick_metro,
   output logic                    gravaM,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [NOTA_W+DUR_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0]       num_notas,
   output logic                    cheio,
   output logic                    fim_gravacao,
   output logic [3:0]              db_estado
);

   estado_t                 r_estado;
   logic [ADDR_W-1:0]       r_addr;
   logic [NOTA_W-1:0]       r_nota;
   logic                    r_enter;
   logic [DUR_W-1:0]        w_dur;
   logic [DUR_W-1:0]        w_dur_gravar;
   logic [ADDR_W-1:0]       w_addr_inc;
   logic                    w_ultimo;
   logic [NOTA_W+DUR_W-1:0] w_marcador;

   contador_duracao #(.DUR_W(DUR_W)) u_dur (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_zera    (r_estado != MEDE),
      .i_conta   (r_estado == MEDE),
      .i_tick    (tick_metro),
      .o_proxima (w_dur)
   );

`ifdef GRAVA_PAUSAS_EN
   logic [DUR_W-1:0] w_pausa;

   contador_duracao #(.DUR_W(DUR_W)) u_pausa (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_zera    (r_estado != ESPERA),
      .i_conta   (r_estado == ESPERA),
      .i_tick    (tick_metro),
      .o_proxima (w_pausa)
   );
`endif

   always_comb begin
      w_dur_gravar = (w_dur == '0) ? {{(DUR_W-1){1'b0}}, 1'b1} : w_dur;
      w_addr_inc   = r_addr + 1'b1;
      w_ultimo     = (w_addr_inc == '1);
      w_marcador   = {{NOTA_W{END_MARKER_NOTA_BIT}}, {DUR_W{1'b0}}};
   end

   assign db_estado = r_estado;

   // Outputs are loaded on the transition into a state so they line up with it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_estado     <= INICIAL;
         r_addr       <= '0;
         r_nota       <= '0;
         r_enter      <= 1'b0;
         gravaM       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         num_notas    <= '0;
         cheio        <= 1'b0;
         fim_gravacao <= 1'b0;
      end else begin
         gravaM <= 1'b0;
         case (r_estado)
            INICIAL: if (iniciar) r_estado <= ZERA;
            ZERA: begin
               r_addr    <= '0;
               num_notas <= '0;
               cheio     <= 1'b0;
               r_enter   <= 1'b0;
               r_estado  <= ESPERA;
            end
            ESPERA: begin
               if (press_enter || nota_feita) begin
                  r_enter <= press_enter;
                  if (!press_enter) r_nota <= nota;
`ifdef GRAVA_PAUSAS_EN
                  if (w_pausa != '0) begin
                     gravaM    <= 1'b1;
                     mem_addr  <= r_addr;
                     mem_wdata <= {{NOTA_W{PAUSA_NOTA_BIT}}, w_pausa};
                     r_estado  <= GRAVA_PAUSA;
                  end else
`endif
                  if (press_enter) begin
                     gravaM    <= 1'b1;
                     mem_addr  <= r_addr;
                     mem_wdata <= w_marcador;
                     r_estado  <= GRAVA_FIM;
                  end else begin
                     r_estado  <= MEDE;
                  end
               end
            end
            MEDE: begin
               if (press_enter) r_enter <= 1'b1;
               if (!nota_feita || press_enter) begin
                  gravaM    <= 1'b1;
                  mem_addr  <= r_addr;
                  mem_wdata <= {r_nota, w_dur_gravar};
                  r_estado  <= GRAVA;
               end
            end
            GRAVA: r_estado <= INCREMENTA;
            INCREMENTA: begin
               r_addr    <= w_addr_inc;
               num_notas <= num_notas + 1'b1;
               if (w_ultimo || r_enter) begin
                  cheio     <= w_ultimo;
                  gravaM    <= 1'b1;
                  mem_addr  <= w_addr_inc;
                  mem_wdata <= w_marcador;
                  r_estado  <= GRAVA_FIM;
               end else begin
                  r_estado  <= ESPERA;
               end
            end
`ifdef GRAVA_PAUSAS_EN
            GRAVA_PAUSA: r_estado <= INCREMENTA_PAUSA;
            INCREMENTA_PAUSA: begin
               r_addr <= w_addr_inc;
               if (w_ultimo || r_enter) begin
                  cheio     <= w_ultimo;
                  gravaM    <= 1'b1;
                  mem_addr  <= w_addr_inc;
                  mem_wdata <= w_marcador;
                  r_estado  <= GRAVA_FIM;
               end else begin
                  r_estado  <= MEDE;
               end
            end
`endif
            GRAVA_FIM: begin
               fim_gravacao <= 1'b1;
               r_estado     <= FIM;
            end
            FIM: begin
               if (iniciar) begin
                  fim_gravacao <= 1'b0;
                  r_estado     <= ZERA;
               end
            end
            default: r_estado <= INICIAL;
         endcase
      end
   end

endmodule

// File: tb/tb_modo2_gravador.sv
// Self-checking bench for modo2_gravador (ADDR_W=3 to reach capacity quickly).
module tb_modo2_gravador;

   localparam int AW = 3;
   localparam int NW = 4;
   localparam int DW = 4;
   localparam logic [3:0] S_INICIAL = 4'd0, S_ESPERA = 4'd2, S_MEDE = 4'd3, S_FIM = 4'd7;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          iniciar = 1'b0;
   logic          press_enter = 1'b0;
   logic          nota_feita = 1'b0;
   logic [NW-1:0] nota = '0;
   logic          tick_metro = 1'b0;
   logic          gravaM;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [AW-1:0] num_notas;
   logic          cheio;
   logic          fim_gravacao;
   logic [3:0]    db_estado;

   modo2_gravador #(.ADDR_W(AW), .NOTA_W(NW), .DUR_W(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .press_enter  (press_enter),
      .nota_feita   (nota_feita),
      .nota         (nota),
      .tick_metro   (tick_metro),
      .gravaM       (gravaM),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .num_notas    (num_notas),
      .cheio        (cheio),
      .fim_gravacao (fim_gravacao),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   logic [AW-1:0] wl_addr[$];
   logic [7:0]    wl_data[$];
   logic [7:0]    exp_q[$];
   bit            seen_espera;

   always @(negedge clock) begin
      if (gravaM === 1'b1) begin
         wl_addr.push_back(mem_addr);
         wl_data.push_back(mem_wdata);
      end
      if (db_estado === S_ESPERA) seen_espera = 1'b1;
   end

   typedef struct {
      int         n;
      int         t;
      bit         tick_rel;
      bit         enter_held;
      logic [7:0] exp_word;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_for(input logic [3:0] a, input logic [3:0] b, input string nm);
      int k = 0;
      while (db_estado !== a && db_estado !== b && k < 40) begin
         step(1);
         k++;
      end
      chk(nm, {31'd0, (db_estado === a || db_estado === b)}, 32'd1);
   endtask

   // Reference rule: duration is the tick count clamped into [1, 2^DW-1].
   function automatic logic [7:0] palavra(input int n, input int t);
      int d;
      d = (t < 1) ? 1 : ((t > 15) ? 15 : t);
      return {n[3:0], d[3:0]};
   endfunction

   task automatic start_session();
      wl_addr.delete();
      wl_data.delete();
      exp_q.delete();
      iniciar = 1'b1;
      step(1);
      iniciar = 1'b0;
      wait_for(S_ESPERA, S_ESPERA, "sessao_espera");
   endtask

   task automatic end_session();
      press_enter = 1'b1;
      step(1);
      press_enter = 1'b0;
      wait_for(S_FIM, S_FIM, "fim");
   endtask

   task automatic ticks(input int t);
      for (int i = 0; i < t; i++) begin
         tick_metro = 1'b1;
         step(1);
         tick_metro = 1'b0;
         step(1);
      end
   endtask

   task automatic press_note(input int n, input int t, input bit tick_rel, input bit enter_rel);
      nota = n[NW-1:0];
      nota_feita = 1'b1;
      wait_for(S_MEDE, S_MEDE, "entra_mede");
      nota = 4'((n % 15) + 1);
      ticks(t);
      seen_espera = 1'b0;
      if (enter_rel) press_enter = 1'b1;
      else nota_feita = 1'b0;
      tick_metro = tick_rel;
      step(1);
      press_enter = 1'b0;
      tick_metro = 1'b0;
      nota_feita = 1'b0;
      if (enter_rel) begin
         wait_for(S_FIM, S_FIM, "fim_apos_enter");
         chk("sem_volta_espera", {31'd0, seen_espera}, 32'd0);
      end else begin
         wait_for(S_ESPERA, S_FIM, "volta_espera");
      end
   endtask

   task automatic check_session(input int nnotas, input bit exp_cheio);
      chk("n_escritas", wl_data.size(), exp_q.size() + 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < wl_data.size()) begin
            chk($sformatf("addr_%0d", i), wl_addr[i], i);
            chk($sformatf("word_%0d", i), wl_data[i], exp_q[i]);
         end
      end
      if (wl_data.size() > exp_q.size()) begin
         chk("marcador_addr", wl_addr[exp_q.size()], exp_q.size());
         chk("marcador_word", wl_data[exp_q.size()], 8'hF0);
      end
      chk("num_notas", num_notas, nnotas);
      chk("fim_gravacao", fim_gravacao, 1);
      chk("cheio", cheio, exp_cheio);
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      vec_t vt[7];
      vt[0] = '{5, 3, 1'b0, 1'b0, 8'h53};
      vt[1] = '{2, 0, 1'b0, 1'b0, 8'h21};
      vt[2] = '{7, 20, 1'b0, 1'b0, 8'h7F};
      vt[3] = '{3, 2, 1'b0, 1'b1, 8'h32};
      vt[4] = '{9, 1, 1'b1, 1'b0, 8'h92};
      vt[5] = '{4, 15, 1'b0, 1'b0, 8'h4F};
      vt[6] = '{1, 14, 1'b1, 1'b1, 8'h1F};

      // Reset state
      step(2);
      chk("rst_estado", db_estado, 0);
      chk("rst_gravaM", gravaM, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_num", num_notas, 0);
      chk("rst_cheio", cheio, 0);
      chk("rst_fim", fim_gravacao, 0);
      reset = 1'b1;
      step(2);
      chk("inicial_sem_iniciar", db_estado, S_INICIAL);

      // Table-driven single-note sessions
      foreach (vt[i]) begin
         start_session();
         press_note(vt[i].n, vt[i].t, vt[i].tick_rel, vt[i].enter_held);
         if (!vt[i].enter_held) end_session();
         exp_q.push_back(vt[i].exp_word);
         check_session(1, 1'b0);
      end

      // Randomized multi-note sessions against the clamp rule
      for (int s = 0; s < 15; s++) begin
         int k;
         bit fin_enter;
         k = $urandom_range(1, 5);
         fin_enter = 1'($urandom_range(0, 1));
         start_session();
         for (int j = 0; j < k; j++) begin
            int n, t;
            bit tr, eh;
            n  = $urandom_range(1, 15);
            t  = $urandom_range(0, 18);
            tr = 1'($urandom_range(0, 1));
            eh = (j == k - 1) && fin_enter;
            press_note(n, t, tr, eh);
            exp_q.push_back(palavra(n, t + int'(tr)));
         end
         if (!fin_enter) end_session();
         check_session(k, 1'b0);
      end

      // Capacity: 7 notes fill ADDR_W=3, marker lands at address 7
      start_session();
      for (int i = 1; i <= 7; i++) begin
         press_note(i, 1, 1'b0, 1'b0);
         exp_q.push_back(palavra(i, 1));
      end
      chk("cheio_estado", db_estado, S_FIM);
      nota = 4'd8;
      nota_feita = 1'b1;
      step(4);
      nota_feita = 1'b0;
      step(2);
      chk("oitava_ignorada", db_estado, S_FIM);
      check_session(7, 1'b1);

`ifdef GRAVA_PAUSAS_EN
      // Two ticks of silence between notes become a rest word
      start_session();
      press_note(1, 1, 1'b0, 1'b0);
      ticks(2);
      press_note(4, 1, 1'b0, 1'b0);
      end_session();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h41);
      check_session(2, 1'b0);
`endif

      // Reset pulled while a note is being measured
      start_session();
      press_note(6, 2, 1'b0, 1'b0);
      press_note(3, 1, 1'b0, 1'b0);
      chk("pre_rst_num", num_notas, 2);
      wl_addr.delete();
      wl_data.delete();
      nota = 4'd5;
      nota_feita = 1'b1;
      wait_for(S_MEDE, S_MEDE, "rst_mede");
      tick_metro = 1'b1;
      step(1);
      tick_metro = 1'b0;
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      chk("rstm_estado", db_estado, S_INICIAL);
      chk("rstm_gravaM", gravaM, 0);
      chk("rstm_addr", mem_addr, 0);
      chk("rstm_wdata", mem_wdata, 0);
      chk("rstm_num", num_notas, 0);
      chk("rstm_cheio", cheio, 0);
      chk("rstm_fim", fim_gravacao, 0);
      nota_feita = 1'b0;
      step(4);
      chk("rstm_sem_escrita", wl_data.size(), 0);
      chk("rstm_fica_inicial", db_estado, S_INICIAL);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
